// File: rtl/fault_pwm_gen.sv
// Fault-aware PWM generator: soft-start ramp, per-period duty latching, level throttling and sticky trip latch.
// Optional dead-time complementary output is built when DEADTIME_EN is defined.
module fault_pwm_gen #(
  parameter int WIDTH    = 8,
  parameter int RAMP_DIV = 4,
  parameter int DEAD     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] duty,
  input  logic [2:0]       fault_code,
  input  logic [1:0]       fault_level,
  input  logic             clear,
  output logic             pwm_out,
  output logic             pwm_n,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] duty_eff,
  output logic [2:0]       fault_latched
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RAMP  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  localparam int              DIV_W    = $clog2(RAMP_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  if (RAMP_DIV < 1 || DEAD < 1 || DEAD >= (2 ** WIDTH) / 2) begin : g_bad_param
    $error("fault_pwm_gen: RAMP_DIV/DEAD out of range");
  end

  function automatic logic [WIDTH-1:0] level_clamp(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return '1;
      2'd1:    return WIDTH'(1) << (WIDTH - 1);
      2'd2:    return WIDTH'(1) << (WIDTH - 2);
      default: return '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] min_duty(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] duty_eff_q, duty_eff_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       fault_latched_q, fault_latched_d;
  logic             pwm_q, pwm_d;

  logic             pb;
  logic             trip;
  logic             div_hit;
  logic [WIDTH-1:0] target;
  logic [WIDTH:0]   ramp_sum;
  logic             active;
  logic             raw;

  assign pb       = (cnt_q == '1);
  assign trip     = (fault_level == 2'd3) && (state_q != S_FAULT);
  assign div_hit  = (div_q == DIV_LAST);
  assign target   = min_duty(duty, level_clamp(fault_level));
  assign ramp_sum = {1'b0, duty_eff_q} + (WIDTH + 1)'(div_hit);

`ifdef DEADTIME_EN
  localparam int              HW       = $clog2(DEAD + 2);
  localparam logic [HW-1:0]   DEAD_SAT = HW'(DEAD + 1);
  logic [HW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic          pwm_n_q, pwm_n_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q           <= '0;
      state_q         <= S_IDLE;
      duty_eff_q      <= '0;
      div_q           <= '0;
      fault_latched_q <= '0;
      pwm_q           <= 1'b0;
`ifdef DEADTIME_EN
      hi_q            <= '0;
      lo_q            <= '0;
      pwm_n_q         <= 1'b0;
`endif
    end else begin
      cnt_q           <= cnt_d;
      state_q         <= state_d;
      duty_eff_q      <= duty_eff_d;
      div_q           <= div_d;
      fault_latched_q <= fault_latched_d;
      pwm_q           <= pwm_d;
`ifdef DEADTIME_EN
      hi_q            <= hi_d;
      lo_q            <= lo_d;
      pwm_n_q         <= pwm_n_d;
`endif
    end
  end

  // Trip preempts everything; clear is only honoured once the trip level has gone away.
  always_comb begin
    cnt_d           = cnt_q + 1'b1;
    state_d         = state_q;
    duty_eff_d      = duty_eff_q;
    div_d           = div_q;
    fault_latched_d = fault_latched_q;
    if (trip) begin
      state_d         = S_FAULT;
      duty_eff_d      = '0;
      div_d           = '0;
      fault_latched_d = fault_code;
    end else if (state_q == S_FAULT) begin
      if (clear && (fault_level != 2'd3)) begin
        state_d         = S_IDLE;
        duty_eff_d      = '0;
        div_d           = '0;
        fault_latched_d = '0;
      end
    end else if (pb) begin
      case (state_q)
        S_IDLE: begin
          if (duty != '0) begin
            state_d = S_RAMP;
            div_d   = '0;
          end
        end
        S_RAMP: begin
          div_d = div_hit ? '0 : div_q + 1'b1;
          if (ramp_sum >= {1'b0, target}) begin
            duty_eff_d = target;
            state_d    = S_RUN;
            div_d      = '0;
          end else begin
            duty_eff_d = ramp_sum[WIDTH-1:0];
          end
        end
        S_RUN: begin
          if (duty == '0) begin
            state_d    = S_IDLE;
            duty_eff_d = '0;
          end else begin
            duty_eff_d = target;
          end
        end
        default: ;
      endcase
    end
  end

  // The raw comparison is masked in the trip cycle so the output drops with one cycle of latency.
  always_comb begin
    active = ((state_q == S_RAMP) || (state_q == S_RUN)) && (fault_level != 2'd3);
    raw    = active && (cnt_q < duty_eff_q);
`ifdef DEADTIME_EN
    hi_d    = raw ? ((hi_q == DEAD_SAT) ? hi_q : hi_q + 1'b1) : '0;
    lo_d    = (active && !raw) ? ((lo_q == DEAD_SAT) ? lo_q : lo_q + 1'b1) : '0;
    pwm_d   = (hi_d == DEAD_SAT);
    pwm_n_d = (lo_d == DEAD_SAT);
`else
    pwm_d   = raw;
`endif
  end

  assign pwm_out       = pwm_q;
  assign state         = state_q;
  assign duty_eff      = duty_eff_q;
  assign fault_latched = fault_latched_q;
`ifdef DEADTIME_EN
  assign pwm_n         = pwm_n_q;
`else
  assign pwm_n         = 1'b0;
`endif

endmodule
